// File: rtl/multiplier_pkg.sv
// Shared definitions for the HI/LO multiply unit: funct codes and control states.
package multiplier_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_OUT   = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
// MULTU starts a WIDTH-iteration multiply; OUT exposes the product register on dataOut.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t               state_r;
    logic [2*WIDTH-1:0]   p_r;
    logic [WIDTH-1:0]     m_r;
    logic [CW-1:0]        cnt_r;

    // One iteration: conditional add into the upper half, then shift right with the add carry.
    function automatic logic [2*WIDTH-1:0] shift_add_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   m
    );
        logic [WIDTH:0] sum;
        if (p[0]) begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
        end else begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]};
        end
        return {sum, p[WIDTH-1:1]};
    endfunction

    // Control FSM and datapath registers; DONE waits for Signal to leave MULTU before re-arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            p_r     <= {(2*WIDTH){1'b0}};
            m_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Signal == FUNCT_MULTU) begin
                        m_r     <= dataA;
                        p_r     <= {{WIDTH{1'b0}}, dataB};
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    p_r   <= shift_add_step(p_r, m_r);
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (Signal != FUNCT_MULTU) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Product is visible only under OUT; reset forces zero regardless of the code.
    always_comb begin
        dataOut = {(2*WIDTH){1'b0}};
        if (!reset && (Signal == FUNCT_OUT)) begin
            dataOut = p_r;
        end else begin
            dataOut = {(2*WIDTH){1'b0}};
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the shift-add multiplier: expected products are queued at
// MULTU launch and popped when OUT is presented.
module tb_multiplier;

    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_OUT   = 6'b111111;
    localparam logic [5:0] C_NOP   = 6'b000000;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;

    int chk_total;
    int chk_pass;
    logic [63:0] exp_q[$];

    multiplier #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        chk_total++;
        if (got === want) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare dataOut against the oldest queued expectation.
    task automatic check_pop(input string tag);
        logic [63:0] want;
        #1;
        if (exp_q.size() == 0) begin
            chk_total++;
            $display("FAIL %s: scoreboard empty, dataOut 0x%016h", tag, dataOut);
        end else begin
            want = exp_q.pop_front();
            check_value(tag, dataOut, want);
        end
    endtask

    // Closed form of P after k iterations: low k bits of B multiplied in, rest of B still shifting.
    function automatic logic [63:0] partial_p(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] blow;
        blow = {32'd0, b} & ((64'd1 << k) - 64'd1);
        return (({32'd0, a} * blow) << (32 - k)) + ({32'd0, b} >> k);
    endfunction

    // Full multiply: 33 MULTU edges, then OUT (whose edge also returns the unit to IDLE).
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
        dataA  = a;
        dataB  = b;
        Signal = C_MULTU;
        exp_q.push_back({32'd0, a} * {32'd0, b});
        repeat (33) tick();
        Signal = C_OUT;
        check_pop(tag);
        tick();
    endtask

    initial begin
        chk_total = 0;
        chk_pass  = 0;
        reset  = 1'b1;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = C_OUT;
        #1;
        check_value("reset_out", dataOut, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check_value("post_reset_out", dataOut, 64'd0);
        Signal = C_NOP;
        repeat (33) tick();

        run_mult("mul_10x20", 32'd10, 32'd20);
        run_mult("mul_5x15", 32'd5, 32'd15);
        run_mult("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mult("mul_a_zero", 32'd0, 32'h1234_5678);
        run_mult("mul_b_zero", 32'hDEAD_BEEF, 32'd0);

        // MULTU held for 60 edges with operands changed after the load: no restart.
        dataA  = 32'd11;
        dataB  = 32'd13;
        Signal = C_MULTU;
        exp_q.push_back(64'd143);
        tick();
        dataA = 32'd7;
        dataB = 32'd9;
        repeat (59) tick();
        check_value("hold_multu_out_zero", dataOut, 64'd0);
        Signal = C_NOP;
        #1;
        check_value("hold_nop_out_zero", dataOut, 64'd0);
        tick();
        Signal = C_OUT;
        check_pop("hold_no_restart");
        tick();

        // Reset ten edges into 123x456 aborts the operation.
        dataA  = 32'd123;
        dataB  = 32'd456;
        Signal = C_MULTU;
        repeat (10) tick();
        reset  = 1'b1;
        Signal = C_OUT;
        #1;
        check_value("abort_during_reset", dataOut, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check_value("abort_after_reset", dataOut, 64'd0);
        tick();
        run_mult("mul_123x456", 32'd123, 32'd456);

        // OUT after 16 iterations shows the partial product; later OUT shows the full one.
        dataA  = 32'd1000;
        dataB  = 32'd1000;
        Signal = C_MULTU;
        exp_q.push_back(partial_p(32'd1000, 32'd1000, 16));
        exp_q.push_back(64'd1000000);
        repeat (17) tick();
        Signal = C_OUT;
        check_pop("partial_iter16");
        repeat (16) tick();
        check_pop("partial_then_full");
        tick();

        for (int i = 0; i < 4; i++) begin
            run_mult("mul_random", $urandom(), $urandom());
        end

        Signal = C_NOP;
        tick();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
